result_checker: RTL and testbench

- Synthesizable post-run self-check engine for the 8-bit core; a parametrised successor to the fixed quicktest bench.
- On `Start` it reads the two operand words and a run of result words from data memory through a one-cycle-latency read port.
- Each result word is compared against a golden operation model, and the block reports a per-check error mask, an error count and pass/fail.
- It sits beside `dm1`, is triggered from `Done`, and is usable in simulation and on silicon.

---
 rtl/result_checker_pkg.sv | 52 +++++
 rtl/result_checker_alu.sv | 19 +
 rtl/result_checker.sv | 139 +++++++++++++
 tb/tb_result_checker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/result_checker_pkg.sv
// Shared types for the post-run result checker: op codes, per-index op table, FSM states
// and a width-generic golden op function (callers zero-extend inputs and truncate the result).
package checker_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_XOR    = 4'd3,
        OP_OR     = 4'd4,
        OP_NOT_A  = 4'd5,
        OP_RXOR_A = 4'd6,
        OP_NOP    = 4'd7,
        OP_INC_A  = 4'd9
    } check_op_e;

    localparam check_op_e CHECK_OP [16] = '{
        OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_OR, OP_NOT_A, OP_RXOR_A, OP_NOP,
        OP_NOP, OP_INC_A, OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP, OP_NOP
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_A,
        ST_RD_B,
        ST_CHK,
        ST_DRAIN,
        ST_FIN
    } state_e;

    localparam int MAX_DW = 64;

    // Inputs must be zero-extended so that reduction XOR only sees the real operand bits.
    function automatic logic [MAX_DW-1:0] expected(input check_op_e op,
                                                   input logic [MAX_DW-1:0] a,
                                                   input logic [MAX_DW-1:0] b);
        logic [MAX_DW-1:0] r;
        case (op)
            OP_ADD:    r = a + b;
            OP_SUB:    r = a - b;
            OP_AND:    r = a & b;
            OP_XOR:    r = a ^ b;
            OP_OR:     r = a | b;
            OP_NOT_A:  r = ~a;
            OP_RXOR_A: r = {{(MAX_DW-1){1'b0}}, ^a};
            OP_INC_A:  r = a + {{(MAX_DW-1){1'b0}}, 1'b1};
            default:   r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/result_checker_alu.sv
// Combinational golden model: op, A, B -> expected DW-bit word (modulo 2^DW).
// Zero latency, no flow control.
module check_alu_model
    import checker_pkg::*;
#(
    parameter int DW = 8
) (
    input  check_op_e     i_op,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_exp
);

    logic [MAX_DW-1:0] w_full;

    assign w_full = expected(i_op, MAX_DW'(i_a), MAX_DW'(i_b));
    assign o_exp  = w_full[DW-1:0];

endmodule

// File: rtl/result_checker.sv
// Post-run self-check: reads A, B and NUM_CHECKS result words, flags mismatches vs golden ops.
// CheckDone NUM_CHECKS+4 cycles after an accepted Start; Start outside IDLE is ignored.
module result_checker
    import checker_pkg::*;
#(
    parameter int DW         = 8,
    parameter int AW         = 8,
    parameter int NUM_CHECKS = 10,
    parameter int OPA_ADDR   = 0,
    parameter int OPB_ADDR   = 1,
    parameter int RES_BASE   = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    output logic                  RdEn,
    output logic [AW-1:0]         RdAddr,
    input  logic [DW-1:0]         RdData,
    output logic                  Busy,
    output logic                  CheckDone,
    output logic [NUM_CHECKS-1:0] ErrMask,
    output logic [4:0]            ErrCount,
    output logic                  Pass
);

    localparam int IW = 4;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CHECKS - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [IW-1:0]         r_idx;
    logic [DW-1:0]         r_a;
    logic [DW-1:0]         r_b;
    logic [NUM_CHECKS-1:0] r_mask;
    logic                  r_pass;

    logic [IW-1:0]         w_cmp_idx;
    logic                  w_cmp_vld;
    check_op_e             w_cmp_op;
    logic [DW-1:0]         w_exp;
    logic                  w_err;
    logic [NUM_CHECKS-1:0] w_err_bits;
    logic                  w_start_acc;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        RdEn        = 1'b0;
        RdAddr      = '0;
        Busy        = 1'b0;
        CheckDone   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) w_state_nxt = ST_RD_A;
            end
            ST_RD_A: begin
                w_state_nxt = ST_RD_B;
                RdEn        = 1'b1;
                RdAddr      = AW'(OPA_ADDR);
                Busy        = 1'b1;
            end
            ST_RD_B: begin
                w_state_nxt = ST_CHK;
                RdEn        = 1'b1;
                RdAddr      = AW'(OPB_ADDR);
                Busy        = 1'b1;
            end
            ST_CHK: begin
                if (r_idx == LAST_IDX) w_state_nxt = ST_DRAIN;
                RdEn   = 1'b1;
                RdAddr = AW'(RES_BASE) + AW'(r_idx);
                Busy   = 1'b1;
            end
            ST_DRAIN: begin
                w_state_nxt = ST_FIN;
                Busy        = 1'b1;
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
                CheckDone   = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Read data trails the address by one cycle, so CHK cycle k sees the word for index k-1.
    assign w_start_acc = (r_state == ST_IDLE) && Start;
    assign w_cmp_vld   = ((r_state == ST_CHK) && (r_idx != '0)) || (r_state == ST_DRAIN);
    assign w_cmp_idx   = (r_state == ST_DRAIN) ? LAST_IDX : (r_idx - 1'b1);
    assign w_cmp_op    = CHECK_OP[w_cmp_idx];

    check_alu_model #(
        .DW (DW)
    ) u_alu (
        .i_op  (w_cmp_op),
        .i_a   (r_a),
        .i_b   (r_b),
        .o_exp (w_exp)
    );

    assign w_err      = w_cmp_vld && (w_cmp_op != OP_NOP) && (RdData != w_exp);
    assign w_err_bits = w_err ? (NUM_CHECKS'(1) << w_cmp_idx) : '0;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_idx  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_mask <= '0;
            r_pass <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_idx  <= '0;
                r_mask <= '0;
                r_pass <= 1'b0;
            end else begin
                r_mask <= r_mask | w_err_bits;
            end
            if (r_state == ST_RD_B) r_a <= RdData;
            if (r_state == ST_CHK) begin
                r_idx <= r_idx + 1'b1;
                if (r_idx == '0) r_b <= RdData;
            end
            if (r_state == ST_DRAIN) r_pass <= ((r_mask | w_err_bits) == '0);
        end
    end

    assign ErrMask  = r_mask;
    assign ErrCount = 5'($countones(r_mask));
    assign Pass     = r_pass;

endmodule

// File: tb/tb_result_checker.sv
module tb_result_checker;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Start;
    logic       RdEn;
    logic [7:0] RdAddr;
    logic [7:0] RdData;
    logic       Busy;
    logic       CheckDone;
    logic [9:0] ErrMask;
    logic [4:0] ErrCount;
    logic       Pass;

    logic [7:0] mem [256];
    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    result_checker dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .RdEn      (RdEn),
        .RdAddr    (RdAddr),
        .RdData    (RdData),
        .Busy      (Busy),
        .CheckDone (CheckDone),
        .ErrMask   (ErrMask),
        .ErrCount  (ErrCount),
        .Pass      (Pass)
    );

    always @(posedge Clk) if (RdEn) RdData <= mem[RdAddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_nop(input int i);
        return (i == 7) || (i == 8);
    endfunction

    function automatic logic [7:0] golden(input int i, input logic [7:0] a, input logic [7:0] b);
        int s;
        int ia = int'(a);
        int ib = int'(b);
        case (i)
            0: s = ia + ib;
            1: s = ia - ib + 256;
            2: s = ia & ib;
            3: s = ia ^ ib;
            4: s = ia | ib;
            5: s = 255 - ia;
            6: s = $countones(a) % 2;
            9: s = ia + 1;
            default: s = 0;
        endcase
        return s[7:0];
    endfunction

    function automatic logic [9:0] model_mask();
        logic [9:0] m = '0;
        for (int i = 0; i < 10; i++)
            if (!is_nop(i) && mem[2+i] != golden(i, mem[0], mem[1])) m[i] = 1'b1;
        return m;
    endfunction

    task automatic load(input logic [7:0] v [12]);
        for (int i = 0; i < 12; i++) mem[i] = v[i];
    endtask

    // Called at #1 after a rising edge with the DUT idle; Start is sampled at the next edge.
    task automatic run_check(input string tag, input bit pulse);
        logic [9:0] exp;
        int cyc;
        int nbusy;
        int seq_err;
        logic [7:0] ea;
        exp     = model_mask();
        nbusy   = 0;
        seq_err = 0;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        cyc = 1;
        chk({tag, "_mask_cleared"}, 32'(ErrMask), 32'h0);
        while (!CheckDone && cyc < 100) begin
            if (Busy) nbusy++;
            ea = (cyc == 1) ? 8'd0 : (cyc == 2) ? 8'd1 : 8'(cyc - 1);
            if (RdEn !== (cyc <= 12)) seq_err++;
            if (cyc <= 12 && RdAddr !== ea) seq_err++;
            Start = pulse && (cyc == 3 || cyc == 8);
            @(posedge Clk); #1;
            cyc++;
        end
        Start = 1'b0;
        chk({tag, "_done_cycle"}, 32'(cyc), 32'd14);
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'd13);
        chk({tag, "_rd_seq_err"}, 32'(seq_err), 32'd0);
        chk({tag, "_busy_at_done"}, 32'(Busy), 32'd0);
        chk({tag, "_mask"}, 32'(ErrMask), 32'(exp));
        chk({tag, "_count"}, 32'(ErrCount), 32'($countones(exp)));
        chk({tag, "_pass"}, 32'(Pass), 32'(exp == 0));
        @(posedge Clk); #1;
        chk({tag, "_idle_after"}, {30'd0, Busy, CheckDone}, 32'd0);
        chk({tag, "_mask_held"}, 32'(ErrMask), 32'(exp));
        chk({tag, "_pass_held"}, 32'(Pass), 32'(exp == 0));
    endtask

    logic [7:0] base  [12] = '{8'hF0, 8'hCC, 8'hBC, 8'h24, 8'hC0, 8'h3C, 8'hFC, 8'h0F,
                               8'h00, 8'h5A, 8'hA5, 8'hF1};
    logic [7:0] wrapv [12] = '{8'hFF, 8'h01, 8'h00, 8'hFE, 8'h01, 8'hFE, 8'hFF, 8'h00,
                               8'h00, 8'h33, 8'hC7, 8'h00};

    initial begin
        int nd;
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        Reset = 1'b0;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_rden", 32'(RdEn), 32'd0);
        chk("rst_rdaddr", 32'(RdAddr), 32'd0);
        chk("rst_busy", 32'(Busy), 32'd0);
        chk("rst_done", 32'(CheckDone), 32'd0);
        chk("rst_mask", 32'(ErrMask), 32'd0);
        chk("rst_count", 32'(ErrCount), 32'd0);
        chk("rst_pass", 32'(Pass), 32'd0);
        @(negedge Clk) Reset = 1'b1;
        @(posedge Clk); #1;

        load(base);
        run_check("golden", 1'b0);
        chk("golden_mask_const", 32'(ErrMask), 32'h000);

        mem[3] = 8'h25;
        run_check("sub_err", 1'b0);
        chk("sub_err_mask_const", 32'(ErrMask), 32'h002);

        load(base);
        mem[8]  = 8'h01;
        mem[9]  = 8'($urandom);
        mem[10] = 8'($urandom);
        run_check("rxor_err", 1'b0);
        chk("rxor_err_mask_const", 32'(ErrMask), 32'h040);

        load(wrapv);
        run_check("wrap", 1'b0);
        chk("wrap_pass_const", 32'(Pass), 32'd1);

        load(base);
        mem[4] = 8'h00;
        run_check("pulses", 1'b1);

        // Reset in the middle of a failing pass.
        load(base);
        mem[2] = 8'h00;
        Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        chk("pre_rst_mask0", 32'(ErrMask[0]), 32'd1);
        #2 Reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(Busy), 32'd0);
        chk("midrst_mask", 32'(ErrMask), 32'd0);
        chk("midrst_rden", 32'(RdEn), 32'd0);
        chk("midrst_done", 32'(CheckDone), 32'd0);
        chk("midrst_pass", 32'(Pass), 32'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk) Reset = 1'b1;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            if (CheckDone || Busy) nd++;
        end
        chk("post_rst_quiet", 32'(nd), 32'd0);
        load(base);
        run_check("after_rst", 1'b0);

        for (int t = 0; t < 8; t++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            mem[0] = a;
            mem[1] = b;
            for (int i = 0; i < 10; i++) begin
                mem[2+i] = golden(i, a, b);
                if (is_nop(i) || $urandom_range(0, 3) == 0)
                    mem[2+i] = mem[2+i] ^ 8'($urandom_range(1, 255));
            end
            run_check($sformatf("rand%0d", t), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
